// File: rtl/cdi_bus_pkg.sv
// Shared types, field widths and helpers for the CD-i CPU bus decoder.
package cdi_bus_pkg;

    localparam int unsigned ADDR_W      = 23;
    localparam int unsigned WAIT_W      = 4;
    localparam int unsigned TO_W        = 8;
    localparam int unsigned IDX_W       = 4;
    localparam int unsigned MAX_REGIONS = 16;

    typedef enum logic [2:0] {
        StIdle,
        StAccess,
        StAck,
        StErr,
        StRelease
    } bus_state_e;

    // Lowest set bit wins, so lower-numbered regions take priority on overlap.
    function automatic logic [IDX_W-1:0] prio_enc(input logic [MAX_REGIONS-1:0] hits);
        prio_enc = '0;
        for (int i = int'(MAX_REGIONS) - 1; i >= 0; i--) begin
            if (hits[i]) prio_enc = IDX_W'(i);
        end
    endfunction

    function automatic logic [MAX_REGIONS-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        idx_onehot = MAX_REGIONS'(1) << idx;
    endfunction

endpackage

// File: rtl/cdi_region_match.sv
// Combinational base/mask compare of the CPU word address against every region,
// producing per-region hit bits and the priority-encoded region index.
module cdi_region_match
    import cdi_bus_pkg::*;
#(
    parameter int unsigned                    NUM_REGIONS = 4,
    parameter logic [NUM_REGIONS*ADDR_W-1:0]  REGION_BASE = '0,
    parameter logic [NUM_REGIONS*ADDR_W-1:0]  REGION_MASK = '0
) (
    input  logic [ADDR_W-1:0]      addr,
    output logic [NUM_REGIONS-1:0] hit,
    output logic [IDX_W-1:0]       idx
);

    always_comb begin
        hit = '0;
        for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
            hit[i] = (addr & REGION_MASK[i*ADDR_W +: ADDR_W]) == REGION_BASE[i*ADDR_W +: ADDR_W];
        end
        idx = prio_enc(MAX_REGIONS'(hit));
    end

endmodule

// File: rtl/cdi_bus_decoder.sv
// CPU-side address decoder and bus-cycle controller: region select, wait states,
// optional external acknowledge, timeout watchdog and unmapped-address bus error.
module cdi_bus_decoder
    import cdi_bus_pkg::*;
#(
    parameter int unsigned                    NUM_REGIONS   = 4,
    parameter int unsigned                    DATA_W        = 16,
    parameter logic [NUM_REGIONS*ADDR_W-1:0]  REGION_BASE   = '0,
    parameter logic [NUM_REGIONS*ADDR_W-1:0]  REGION_MASK   = '0,
    parameter logic [NUM_REGIONS*WAIT_W-1:0]  REGION_WAIT   = '0,
    parameter logic [NUM_REGIONS-1:0]         REGION_EXTACK = '0,
    parameter int unsigned                    TIMEOUT       = 255
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          cpu_as,
    input  logic                          cpu_uds,
    input  logic                          cpu_lds,
    input  logic                          cpu_write_strobe,
    input  logic [ADDR_W-1:0]             cpu_addr,
    output logic                          cpu_bus_ack,
    output logic                          cpu_bus_err,
    output logic [DATA_W-1:0]             cpu_data_in,
    output logic [NUM_REGIONS-1:0]        region_cs,
    output logic [NUM_REGIONS-1:0]        region_start,
    input  logic [NUM_REGIONS-1:0]        region_ack,
    input  logic [NUM_REGIONS*DATA_W-1:0] region_dout
);

    bus_state_e               state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [WAIT_W-1:0]        wait_q, wait_d;
    logic [TO_W-1:0]          to_q, to_d;
    logic [DATA_W-1:0]        data_q, data_d;
    logic                     ack_q, ack_d;
    logic                     err_q, err_d;
    logic [NUM_REGIONS-1:0]   cs_q, cs_d;
    logic [NUM_REGIONS-1:0]   start_q, start_d;

    logic [NUM_REGIONS-1:0]   match_hit;
    logic [IDX_W-1:0]         match_idx;
    logic                     match_any;
    logic [WAIT_W-1:0]        match_wait;
    logic [MAX_REGIONS-1:0]   match_oh;
    logic [MAX_REGIONS-1:0]   active_oh;
    logic                     sel_extack;
    logic                     sel_ack;
    logic [DATA_W-1:0]        sel_dout;
    logic                     request;
    logic                     timeout_hit;
    logic                     unused_write;

    // Read/write sequencing is identical; the direction is not needed here.
    assign unused_write = cpu_write_strobe;

    assign request     = cpu_as && (cpu_uds || cpu_lds);
    assign match_any   = |match_hit;
    assign match_oh    = idx_onehot(match_idx);
    assign active_oh   = idx_onehot(idx_q);
    assign timeout_hit = (TIMEOUT != 0) && (to_q == TO_W'(TIMEOUT));

    cdi_region_match #(
        .NUM_REGIONS (NUM_REGIONS),
        .REGION_BASE (REGION_BASE),
        .REGION_MASK (REGION_MASK)
    ) u_match (
        .addr (cpu_addr),
        .hit  (match_hit),
        .idx  (match_idx)
    );

    always_comb begin
        match_wait = '0;
        sel_extack = 1'b0;
        sel_ack    = 1'b0;
        sel_dout   = '0;
        for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
            if (match_idx == IDX_W'(i)) match_wait = REGION_WAIT[i*WAIT_W +: WAIT_W];
            if (idx_q == IDX_W'(i)) begin
                sel_extack = REGION_EXTACK[i];
                sel_ack    = region_ack[i];
                sel_dout   = region_dout[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        to_d    = to_q;
        data_d  = data_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        cs_d    = '0;
        start_d = '0;

        unique case (state_q)
            StIdle: begin
                if (request) begin
                    if (match_any) begin
                        state_d = StAccess;
                        idx_d   = match_idx;
                        wait_d  = match_wait;
                        to_d    = '0;
                        cs_d    = match_oh[NUM_REGIONS-1:0];
                        start_d = match_oh[NUM_REGIONS-1:0];
                    end else begin
                        state_d = StErr;
                    end
                end
            end
            StAccess: begin
                if (!cpu_as) begin
                    state_d = StIdle;
                end else if (wait_q == '0 && (!sel_extack || sel_ack)) begin
                    state_d = StAck;
                    data_d  = sel_dout;
                    ack_d   = 1'b1;
                    cs_d    = active_oh[NUM_REGIONS-1:0];
                end else if (timeout_hit) begin
                    state_d = StErr;
                    err_d   = 1'b1;
                end else begin
                    cs_d = active_oh[NUM_REGIONS-1:0];
                    to_d = to_q + TO_W'(1);
                    if (wait_q != '0) wait_d = wait_q - WAIT_W'(1);
                end
            end
            StAck: begin
                state_d = StRelease;
            end
            StErr: begin
                // An unmapped request enters here with the pulse not yet shown;
                // a timeout enters with it already raised. Leave once it has been seen.
                if (err_q) begin
                    state_d = StRelease;
                end else begin
                    err_d = 1'b1;
                end
            end
            StRelease: begin
                if (!cpu_as) state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            wait_q  <= '0;
            to_q    <= '0;
            data_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            cs_q    <= '0;
            start_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            to_q    <= to_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            cs_q    <= cs_d;
            start_q <= start_d;
        end
    end

    assign cpu_bus_ack  = ack_q;
    assign cpu_bus_err  = err_q;
    assign cpu_data_in  = data_q;
    assign region_cs    = cs_q;
    assign region_start = start_q;

endmodule

// File: tb/tb_cdi_bus_decoder.sv
// Self-checking bench for cdi_bus_decoder: directed and random bus cycles compared
// cycle by cycle against a transaction-level timing model.
module tb_cdi_bus_decoder;

    localparam int NR  = 4;
    localparam int DW  = 16;
    localparam int TMO = 20;

    localparam logic [NR*23-1:0] P_BASE = {23'h000000, 23'h400000, 23'h200000, 23'h000000};
    localparam logic [NR*23-1:0] P_MASK = {23'h700000, 23'h600000, 23'h600000, 23'h600000};
    localparam logic [NR*4-1:0]  P_WAIT = {4'd1, 4'd0, 4'd3, 4'd0};
    localparam logic [NR-1:0]    P_EXT  = 4'b0100;

    // Model view of the region table, indexed by region number.
    int unsigned m_base[NR] = '{32'h000000, 32'h200000, 32'h400000, 32'h000000};
    int unsigned m_mask[NR] = '{32'h600000, 32'h600000, 32'h600000, 32'h700000};
    int          m_wait[NR] = '{0, 3, 0, 1};
    bit          m_ext[NR]  = '{1'b0, 1'b0, 1'b1, 1'b0};

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             cpu_as = 1'b0;
    logic             cpu_uds = 1'b0;
    logic             cpu_lds = 1'b0;
    logic             cpu_write_strobe = 1'b0;
    logic [22:0]      cpu_addr = '0;
    logic             cpu_bus_ack;
    logic             cpu_bus_err;
    logic [DW-1:0]    cpu_data_in;
    logic [NR-1:0]    region_cs;
    logic [NR-1:0]    region_start;
    logic [NR-1:0]    region_ack = '0;
    logic [NR*DW-1:0] region_dout = '0;

    int            vectors = 0;
    int            miscompares = 0;
    int            txn_no = 0;
    logic [DW-1:0] model_data = '0;

    always #5 clk = ~clk;

    cdi_bus_decoder #(
        .NUM_REGIONS   (NR),
        .DATA_W        (DW),
        .REGION_BASE   (P_BASE),
        .REGION_MASK   (P_MASK),
        .REGION_WAIT   (P_WAIT),
        .REGION_EXTACK (P_EXT),
        .TIMEOUT       (TMO)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .cpu_as           (cpu_as),
        .cpu_uds          (cpu_uds),
        .cpu_lds          (cpu_lds),
        .cpu_write_strobe (cpu_write_strobe),
        .cpu_addr         (cpu_addr),
        .cpu_bus_ack      (cpu_bus_ack),
        .cpu_bus_err      (cpu_bus_err),
        .cpu_data_in      (cpu_data_in),
        .region_cs        (region_cs),
        .region_start     (region_start),
        .region_ack       (region_ack),
        .region_dout      (region_dout)
    );

    function automatic int model_region(input logic [22:0] a);
        for (int i = 0; i < NR; i++) begin
            if ((32'(a) & m_mask[i]) == m_base[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [31:0] observe();
        return {6'b0, cpu_bus_ack, cpu_bus_err, region_start, region_cs, cpu_data_in};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus cycle, starting at a falling edge (cycle 0). ack_at: cycle in which
    // region_ack of the target is raised (-1 never); abort_at: cycle in which cpu_as
    // drops before completion (-1 none); dout_fix: forced read data (-1 random).
    task automatic run_txn(input logic [22:0] addr, input logic wr, input int ack_at,
                           input int abort_at, input int dout_fix);
        int            r, cx, ack_c, err_c, cs_last, drop_c, last_c;
        logic [DW-1:0] dout;
        logic [NR-1:0] es, ec;
        logic [DW-1:0] ed;
        logic [1:0]    strobes;

        txn_no++;
        r = model_region(addr);
        for (int i = 0; i < NR; i++) region_dout[i*DW +: DW] = DW'($urandom);
        if (r >= 0 && dout_fix >= 0) region_dout[r*DW +: DW] = DW'(dout_fix);
        dout = (r >= 0) ? region_dout[r*DW +: DW] : '0;

        if (r < 0) begin
            ack_c = -1; err_c = 2; cs_last = 0; drop_c = 4;
        end else begin
            if (!m_ext[r])       cx = 1 + m_wait[r];
            else if (ack_at < 0) cx = 1000;
            else                 cx = (ack_at > 1 + m_wait[r]) ? ack_at : 1 + m_wait[r];
            if (abort_at >= 1 && abort_at <= cx && abort_at <= TMO + 1) begin
                ack_c = -1; err_c = -1; cs_last = abort_at; drop_c = abort_at;
            end else if (cx <= TMO + 1) begin
                ack_c = cx + 1; err_c = -1; cs_last = cx + 1; drop_c = ack_c + 2;
            end else begin
                ack_c = -1; err_c = TMO + 2; cs_last = TMO + 1; drop_c = err_c + 2;
            end
        end
        last_c = drop_c + 2;

        strobes = 2'($urandom_range(1, 3));
        cpu_addr = addr;
        cpu_write_strobe = wr;
        cpu_as = 1'b1;
        {cpu_uds, cpu_lds} = strobes;
        region_ack = '0;

        for (int k = 1; k <= last_c; k++) begin
            @(negedge clk);
            es = '0;
            ec = '0;
            if (r >= 0 && k == 1) es[r] = 1'b1;
            if (r >= 0 && k <= cs_last) ec[r] = 1'b1;
            ed = (ack_c > 0 && k >= ack_c) ? dout : model_data;
            chk($sformatf("txn%0d_cyc%0d", txn_no, k), observe(),
                {6'b0, 1'(k == ack_c), 1'(k == err_c), es, ec, ed});
            if (r >= 0 && k == ack_at) region_ack[r] = 1'b1;
            if (k == drop_c) begin
                cpu_as = 1'b0;
                cpu_uds = 1'b0;
                cpu_lds = 1'b0;
            end
        end
        region_ack = '0;
        if (ack_c > 0) model_data = dout;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [22:0] ra;
        int          cat, aa, ab;

        #1;
        chk("reset_state", observe(), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Region 0 read, zero waits.
        run_txn(23'h000000, 1'b0, -1, -1, 32'h1234);
        // Region 1 write, three waits.
        run_txn(23'h200000, 1'b1, -1, -1, -1);
        // Region 2 external ack raised in cycle 7, then never, then the timeout boundary.
        run_txn(23'h400000, 1'b0, 7, -1, -1);
        run_txn(23'h400000, 1'b0, -1, -1, -1);
        run_txn(23'h400000, 1'b0, TMO + 1, -1, -1);
        run_txn(23'h400000, 1'b1, TMO + 2, -1, -1);
        // Unmapped address.
        run_txn(23'h700000, 1'b0, -1, -1, -1);
        // Regions 0 and 3 overlap here; region 0 must win.
        run_txn(23'h000010, 1'b0, -1, -1, -1);
        // Abort during waits, then a normal cycle.
        run_txn(23'h200000, 1'b0, -1, 2, -1);
        run_txn(23'h200000, 1'b0, -1, -1, -1);

        // Address strobe without byte strobes is not a request.
        cpu_addr = 23'h000000;
        cpu_as = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("no_strobe_%0d", k), observe(), {16'h0, model_data});
        end
        cpu_as = 1'b0;
        @(negedge clk);

        // Reset in the middle of a waited access.
        cpu_addr = 23'h200000;
        cpu_as = 1'b1;
        cpu_uds = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("reset_mid_access", observe(), 32'h0);
        model_data = '0;
        cpu_as = 1'b0;
        cpu_uds = 1'b0;
        @(negedge clk);
        chk("reset_held", observe(), 32'h0);
        reset_n = 1'b1;
        @(negedge clk);
        run_txn(23'h000000, 1'b0, -1, -1, -1);

        // Random cycles across all regions and the unmapped window.
        for (int n = 0; n < 40; n++) begin
            cat = int'($urandom_range(0, 3));
            ra = {cat[1:0], 21'($urandom)};
            aa = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(1, TMO + 2));
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 4)) : -1;
            run_txn(ra, 1'($urandom), aa, ab, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
